// File: rtl/lsu_mem_port_pkg.sv
// Shared codes, FSM encoding and access-size helpers for the MEM-stage load/store unit.
// Decode codes mirror the pipeline's defines so decode output can be wired straight in.
package lsu_mem_port_pkg;

  localparam logic [3:0] RAM_WE_N = 4'b0000;
  localparam logic [3:0] RAM_WE_B = 4'b0001;
  localparam logic [3:0] RAM_WE_H = 4'b0011;
  localparam logic [3:0] RAM_WE_W = 4'b1111;

  localparam logic [2:0] RAM_EXT_N  = 3'd0;
  localparam logic [2:0] RAM_EXT_B  = 3'd1;
  localparam logic [2:0] RAM_EXT_BU = 3'd2;
  localparam logic [2:0] RAM_EXT_H  = 3'd3;
  localparam logic [2:0] RAM_EXT_HU = 3'd4;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  ext_op;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } lsu_acc_t;

  // Loads size from the extension code, stores from the write code; unknown codes act as word.
  function automatic lsu_size_e access_size(input logic       is_load,
                                            input logic [3:0] ram_we,
                                            input logic [2:0] ext_op);
    lsu_size_e sz;
    sz = SZ_WORD;
    if (is_load) begin
      case (ext_op)
        RAM_EXT_B, RAM_EXT_BU: sz = SZ_BYTE;
        RAM_EXT_H, RAM_EXT_HU: sz = SZ_HALF;
        default:               sz = SZ_WORD;
      endcase
    end else begin
      case (ram_we)
        RAM_WE_B: sz = SZ_BYTE;
        RAM_WE_H: sz = SZ_HALF;
        default:  sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] addr_lo);
    logic mis;
    case (sz)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// SRAM-like request/response data bus between the load/store unit (master) and memory (slave).
interface lsu_mem_port_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/lsu_mem_port_load_ext.sv
// Load lane select and sign/zero extension: shifts the addressed bytes down to bit 0.
module lsu_load_ext
  import lsu_mem_port_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ext_op,
  output logic [31:0] result
);

  logic [31:0] raw;

  always_comb begin
    raw = rdata >> {addr_lo, 3'b000};
    case (ext_op)
      RAM_EXT_B:  result = {{24{raw[7]}}, raw[7:0]};
      RAM_EXT_BU: result = {24'h0, raw[7:0]};
      RAM_EXT_H:  result = {{16{raw[15]}}, raw[15:0]};
      RAM_EXT_HU: result = {16'h0, raw[15:0]};
      default:    result = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit: turns decode store/load codes into single bus transactions
// and stalls the pipeline until each completes; misaligned accesses pulse lsu_ale instead.
//
// state | meaning
// IDLE  | no access in flight; accept an aligned mem_op, flag a misaligned one
// REQ   | data_req held with latched fields until data_addr_ok
// WAIT  | request accepted, waiting for data_data_ok
// DONE  | one-cycle lsu_done, pipeline released
module lsu_mem_port
  import lsu_mem_port_pkg::*;
(
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  mem_valid,
  input  logic [3:0]            mem_ram_we,
  input  logic [2:0]            mem_ram_ext_op,
  input  logic                  mem_is_load,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic [31:0]           lsu_rdata,
  output logic                  lsu_ale,
  lsu_mem_port_if.master        bus
);

  lsu_state_e  state, state_nxt;
  lsu_acc_t    acc_q, acc_new;
  lsu_size_e   sz;
  logic        mem_op, misaligned, accept, capture, req;
  logic [31:0] ext_result;

  assign mem_op     = mem_valid & (mem_is_load | (mem_ram_we != RAM_WE_N));
  assign sz         = access_size(mem_is_load, mem_ram_we, mem_ram_ext_op);
  assign misaligned = is_misaligned(sz, mem_addr[1:0]);

  // Store lanes are replicated so the bus can pick whichever byte lanes the strobes enable.
  always_comb begin
    acc_new.addr   = mem_addr;
    acc_new.ext_op = mem_ram_ext_op;
    acc_new.wr     = ~mem_is_load;
    acc_new.wstrb  = 4'b0000;
    acc_new.wdata  = 32'h0;
    if (!mem_is_load) begin
      case (sz)
        SZ_BYTE: begin
          acc_new.wstrb = 4'b0001 << mem_addr[1:0];
          acc_new.wdata = {4{mem_wdata[7:0]}};
        end
        SZ_HALF: begin
          acc_new.wstrb = 4'b0011 << mem_addr[1:0];
          acc_new.wdata = {2{mem_wdata[15:0]}};
        end
        default: begin
          acc_new.wstrb = 4'b1111;
          acc_new.wdata = mem_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) state <= LSU_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    req       = 1'b0;
    lsu_stall = 1'b0;
    lsu_done  = 1'b0;
    lsu_ale   = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            lsu_ale = 1'b1;
          end else begin
            accept    = 1'b1;
            lsu_stall = 1'b1;
            state_nxt = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        req       = 1'b1;
        lsu_stall = 1'b1;
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            capture   = 1'b1;
            state_nxt = LSU_DONE;
          end else begin
            state_nxt = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        lsu_stall = 1'b1;
        if (bus.data_data_ok) begin
          capture   = 1'b1;
          state_nxt = LSU_DONE;
        end
      end
      LSU_DONE: begin
        lsu_done  = 1'b1;
        state_nxt = LSU_IDLE;
      end
      default: state_nxt = LSU_IDLE;
    endcase
    // Reset abandons any access in flight; a late data_data_ok then lands in IDLE and is dropped.
    if (cpu_rst) begin
      state_nxt = LSU_IDLE;
      accept    = 1'b0;
      capture   = 1'b0;
      req       = 1'b0;
      lsu_stall = 1'b0;
      lsu_done  = 1'b0;
      lsu_ale   = 1'b0;
    end
  end

  lsu_load_ext u_load_ext (
    .rdata   (bus.data_rdata),
    .addr_lo (acc_q.addr[1:0]),
    .ext_op  (acc_q.ext_op),
    .result  (ext_result)
  );

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      acc_q     <= '0;
      lsu_rdata <= 32'h0;
    end else begin
      if (accept)               acc_q     <= acc_new;
      if (capture && !acc_q.wr) lsu_rdata <= ext_result;
    end
  end

  assign bus.data_req   = req;
  assign bus.data_wr    = acc_q.wr;
  assign bus.data_wstrb = acc_q.wstrb;
  assign bus.data_addr  = acc_q.addr;
  assign bus.data_wdata = acc_q.wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed cases plus randomized accesses against a byte-level model.
module tb_lsu_mem_port;
  import lsu_mem_port_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        mem_valid, mem_is_load;
  logic [3:0]  mem_ram_we;
  logic [2:0]  mem_ram_ext_op;
  logic [31:0] mem_addr, mem_wdata;
  logic        lsu_stall, lsu_done, lsu_ale;
  logic [31:0] lsu_rdata;

  lsu_mem_port_if bus();

  lsu_mem_port dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .mem_valid      (mem_valid),
    .mem_ram_we     (mem_ram_we),
    .mem_ram_ext_op (mem_ram_ext_op),
    .mem_is_load    (mem_is_load),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .lsu_stall      (lsu_stall),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .lsu_ale        (lsu_ale),
    .bus            (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_rdata;

  // kinds: 0 ld.b, 1 ld.bu, 2 ld.h, 3 ld.hu, 4 ld.w, 5 st.b, 6 st.h, 7 st.w
  int          obs_stall, obs_ale, obs_done, obs_done_cyc, obs_req;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_wr, obs_stable, obs_timeout;

  function automatic int m_size(input int kind);
    if (kind == 0 || kind == 1 || kind == 5) return 1;
    if (kind == 2 || kind == 3 || kind == 6) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_wstrb(input int kind, input logic [31:0] addr);
    logic [3:0] s = 4'b0000;
    int sz  = m_size(kind);
    int off = int'(addr[1:0]);
    if (kind < 5) return 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input int kind, input logic [31:0] w);
    logic [31:0] r;
    int sz = m_size(kind);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input int kind, input logic [31:0] addr, input logic [31:0] d);
    longint v = 0;
    int sz  = m_size(kind);
    int off = int'(addr[1:0]);
    for (int i = sz - 1; i >= 0; i--) v = v * 256 + longint'(d[8*(off+i) +: 8]);
    if ((kind == 0 || kind == 2) && v >= (longint'(1) << (8*sz - 1))) v = v - (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  function automatic bit m_misaligned(input int kind, input logic [31:0] addr);
    return (int'(addr[1:0]) % m_size(kind)) != 0;
  endfunction

  task automatic drive_op(input int kind);
    mem_is_load    = (kind < 5);
    mem_ram_we     = RAM_WE_N;
    mem_ram_ext_op = RAM_EXT_N;
    case (kind)
      0: mem_ram_ext_op = RAM_EXT_B;
      1: mem_ram_ext_op = RAM_EXT_BU;
      2: mem_ram_ext_op = RAM_EXT_H;
      3: mem_ram_ext_op = RAM_EXT_HU;
      5: mem_ram_we = RAM_WE_B;
      6: mem_ram_we = RAM_WE_H;
      7: mem_ram_we = RAM_WE_W;
      default: ;
    endcase
  endtask

  // Drives one access and responds as a bus: addr_ok after a req cycles, data_ok d cycles later
  // (or together with addr_ok when fast); spur injects data_ok without addr_ok while requesting.
  task automatic do_access(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int a, input int d,
                           input bit fast, input bit spur);
    int rq = 0;
    int wt = 0;
    bit acc = 0;
    bit fin = 0;
    @(posedge cpu_clk); #1;
    mem_valid = 1'b1; drive_op(kind); mem_addr = addr; mem_wdata = wdata;
    obs_stall = 0; obs_ale = 0; obs_done = 0; obs_done_cyc = -1; obs_req = 0;
    obs_stable = 1'b1; obs_timeout = 1'b0; obs_rdata = 32'h0;
    obs_addr = 32'h0; obs_wdata = 32'h0; obs_wstrb = 4'h0; obs_wr = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge cpu_clk);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = rdata;
      if (lsu_stall) obs_stall++;
      if (lsu_ale) obs_ale++;
      if (lsu_done) begin
        obs_done++; obs_done_cyc = cyc; obs_rdata = lsu_rdata; fin = 1; mem_valid = 1'b0;
      end
      if (bus.data_req) begin
        obs_req++;
        if (rq == 0) begin
          obs_addr = bus.data_addr; obs_wdata = bus.data_wdata;
          obs_wstrb = bus.data_wstrb; obs_wr = bus.data_wr;
        end else if (bus.data_addr !== obs_addr || bus.data_wdata !== obs_wdata ||
                     bus.data_wstrb !== obs_wstrb || bus.data_wr !== obs_wr) begin
          obs_stable = 1'b0;
        end
        if (rq == a) begin
          bus.data_addr_ok = 1'b1; acc = 1;
          if (fast) bus.data_data_ok = 1'b1;
        end else if (spur) begin
          bus.data_data_ok = 1'b1;
        end
        rq++;
      end else if (acc && !fast) begin
        if (wt == d) bus.data_data_ok = 1'b1;
        wt++;
      end
      if (cyc == 0 && lsu_ale) mem_valid = 1'b0;
      if (fin) break;
      if (obs_ale > 0 && cyc >= 3) break;
    end
    if (!fin && obs_ale == 0) obs_timeout = 1'b1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; mem_valid = 1'b1; drive_op(4); mem_addr = 32'h0; mem_wdata = 32'h0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    repeat (3) @(negedge cpu_clk);
    checks++;
    if (lsu_stall !== 1'b0 || lsu_done !== 1'b0 || lsu_ale !== 1'b0 || bus.data_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: stall/done/ale/req got %b%b%b%b want 0000",
               lsu_stall, lsu_done, lsu_ale, bus.data_req);
    end
    checks++;
    if (lsu_rdata !== 32'h0 || bus.data_addr !== 32'h0 || bus.data_wdata !== 32'h0 ||
        bus.data_wstrb !== 4'h0 || bus.data_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: rdata %h addr %h wdata %h wstrb %b wr %b want all zero",
               lsu_rdata, bus.data_addr, bus.data_wdata, bus.data_wstrb, bus.data_wr);
    end
    mem_valid = 1'b0;
    @(posedge cpu_clk); #1 cpu_rst = 1'b0;
    prev_rdata = 32'h0;
  endtask

  task automatic test_plan_cases();
    do_access(0, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 0, 0);
    checks++;
    if (obs_rdata !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL ld_b_rdata: got %h want ffffff80", obs_rdata);
    end
    checks++;
    if (obs_done_cyc !== 3 || obs_stall !== 3) begin
      errors++; $display("FAIL ld_b_timing: done cycle %0d stall %0d want 3 3", obs_done_cyc, obs_stall);
    end
    do_access(3, 32'h0000_1002, 32'h0, 32'hBEEF_1234, 0, 0, 0, 0);
    checks++;
    if (obs_rdata !== 32'h0000_BEEF) begin
      errors++; $display("FAIL ld_hu_rdata: got %h want 0000beef", obs_rdata);
    end
    prev_rdata = 32'h0000_BEEF;
    do_access(5, 32'h0000_2001, 32'h1234_56AB, 32'h5555_5555, 0, 0, 0, 0);
    checks++;
    if (obs_wr !== 1'b1 || obs_wstrb !== 4'b0010 || obs_wdata !== 32'hABAB_ABAB) begin
      errors++;
      $display("FAIL st_b_bus: wr %b wstrb %b wdata %h want 1 0010 abababab", obs_wr, obs_wstrb, obs_wdata);
    end
    checks++;
    if (obs_rdata !== prev_rdata) begin
      errors++; $display("FAIL st_b_rdata_hold: got %h want %h", obs_rdata, prev_rdata);
    end
    do_access(7, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 3, 1, 0, 0);
    checks++;
    if (obs_stall !== 7 || obs_done !== 1 || obs_stable !== 1'b1 || obs_addr !== 32'h0000_2004 ||
        obs_wstrb !== 4'b1111) begin
      errors++;
      $display("FAIL bus_wait: stall %0d done %0d stable %b addr %h wstrb %b want 7 1 1 00002004 1111",
               obs_stall, obs_done, obs_stable, obs_addr, obs_wstrb);
    end
    @(negedge cpu_clk);
    checks++;
    if (lsu_done !== 1'b0) begin
      errors++; $display("FAIL bus_wait_single_done: lsu_done got %b want 0", lsu_done);
    end
    do_access(4, 32'h0000_3002, 32'h0, 32'h0, 0, 0, 0, 0);
    checks++;
    if (obs_ale !== 1 || obs_req !== 0 || obs_stall !== 0 || obs_done !== 0) begin
      errors++;
      $display("FAIL misaligned: ale %0d req %0d stall %0d done %0d want 1 0 0 0",
               obs_ale, obs_req, obs_stall, obs_done);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int kind = int'($urandom_range(0, 7));
      logic [31:0] addr = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rd = $urandom;
      int a = int'($urandom_range(0, 3));
      int d = int'($urandom_range(0, 3));
      bit fast = ($urandom_range(0, 3) == 0);
      bit spur = ($urandom_range(0, 1) == 1);
      int exp_cyc;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'(int'(addr[1:0]) / m_size(kind) * m_size(kind));
      exp_cyc = fast ? 2 + a : 3 + a + d;
      do_access(kind, addr, wd, rd, a, d, fast, spur);
      if (m_misaligned(kind, addr)) begin
        checks++;
        if (obs_ale !== 1 || obs_req !== 0 || obs_stall !== 0 || obs_done !== 0) begin
          errors++;
          $display("FAIL rnd_ale[%0d]: ale %0d req %0d stall %0d done %0d want 1 0 0 0",
                   n, obs_ale, obs_req, obs_stall, obs_done);
        end
        continue;
      end
      checks++;
      if (obs_timeout || obs_done !== 1 || obs_done_cyc !== exp_cyc || obs_stall !== exp_cyc ||
          obs_req !== a + 1 || obs_ale !== 0) begin
        errors++;
        $display("FAIL rnd_timing[%0d]: timeout %b done %0d@%0d stall %0d req %0d ale %0d want 0 1@%0d %0d %0d 0",
                 n, obs_timeout, obs_done, obs_done_cyc, obs_stall, obs_req, obs_ale,
                 exp_cyc, exp_cyc, a + 1);
      end
      checks++;
      if (obs_addr !== addr || obs_wr !== (kind >= 5) || obs_wstrb !== m_wstrb(kind, addr) ||
          obs_stable !== 1'b1) begin
        errors++;
        $display("FAIL rnd_req[%0d]: addr %h wr %b wstrb %b stable %b want %h %b %b 1",
                 n, obs_addr, obs_wr, obs_wstrb, obs_stable, addr, kind >= 5, m_wstrb(kind, addr));
      end
      if (kind >= 5) begin
        checks++;
        if (obs_wdata !== m_wdata(kind, wd) || obs_rdata !== prev_rdata) begin
          errors++;
          $display("FAIL rnd_store[%0d]: wdata %h rdata %h want %h %h",
                   n, obs_wdata, obs_rdata, m_wdata(kind, wd), prev_rdata);
        end
      end else begin
        prev_rdata = m_load(kind, addr, rd);
        checks++;
        if (obs_rdata !== prev_rdata) begin
          errors++; $display("FAIL rnd_load[%0d]: kind %0d rdata %h want %h", n, kind, obs_rdata, prev_rdata);
        end
      end
    end
  endtask

  task automatic test_spurious_idle();
    int dn = 0;
    int st = 0;
    @(posedge cpu_clk); #1 mem_valid = 1'b0;
    @(negedge cpu_clk); bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1357_9BDF;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk); bus.data_data_ok = 1'b0;
      if (lsu_done) dn++;
      if (lsu_stall || bus.data_req) st++;
    end
    checks++;
    if (dn !== 0 || st !== 0 || lsu_rdata !== prev_rdata) begin
      errors++;
      $display("FAIL idle_data_ok: done %0d busy %0d rdata %h want 0 0 %h", dn, st, lsu_rdata, prev_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    int dn = 0;
    int bz = 0;
    @(posedge cpu_clk); #1;
    mem_valid = 1'b1; drive_op(4); mem_addr = 32'h0000_4000;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    bus.data_addr_ok = bus.data_req;
    @(negedge cpu_clk);
    bus.data_addr_ok = 1'b0;
    checks++;
    if (lsu_stall !== 1'b1 || bus.data_req !== 1'b0) begin
      errors++; $display("FAIL wait_entry: stall %b req %b want 1 0", lsu_stall, bus.data_req);
    end
    cpu_rst = 1'b1; mem_valid = 1'b0;
    @(negedge cpu_clk);
    checks++;
    if (lsu_stall !== 1'b0) begin
      errors++; $display("FAIL rst_stall_forced: stall %b want 0", lsu_stall);
    end
    cpu_rst = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clk); bus.data_data_ok = 1'b0;
      if (lsu_done) dn++;
      if (lsu_stall || bus.data_req) bz++;
    end
    checks++;
    if (dn !== 0 || bz !== 0 || lsu_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_in_wait: done %0d busy %0d rdata %h want 0 0 00000000", dn, bz, lsu_rdata);
    end
    prev_rdata = 32'h0;
  endtask

  initial begin
    test_reset();
    test_plan_cases();
    test_random();
    test_spurious_idle();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
